// File: rtl/fp4_mm_pkg.sv
// Shared constants and types for the FP4 x INT8 systolic array datapath.
package fp4_mm_pkg;

    localparam int ACC_W     = 24;
    localparam int SHIFT_MAX = 23;
    localparam int INT8_MIN  = -128;
    localparam int INT8_MAX  = 127;

    // Number of accumulator values produced by an array of the given slice count.
    function automatic int num_values(input int slices);
        return 2 * slices * slices;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fp4_requant.sv
// Combinational requantizer: signed accumulator -> INT8 with round-half-up
// arithmetic shift, optional ReLU, then saturation.
module fp4_requant
    import fp4_mm_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [4:0]       shift,
    input  logic             relu_en,
    output logic [7:0]       q
);

    logic [4:0]              sh;
    logic signed [ACC_W:0]   ext;
    logic signed [ACC_W:0]   bias;
    logic signed [ACC_W:0]   t;
    logic signed [ACC_W:0]   lo;
    logic signed [ACC_W:0]   hi;

    // One extra bit of headroom keeps acc + half-LSB from wrapping at +max.
    always_comb begin
        sh   = (shift > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift;
        ext  = $signed({acc[ACC_W-1], acc});
        bias = (sh == 5'd0) ? '0 : $signed((ACC_W+1)'(1) << (sh - 5'd1));
        t    = (ext + bias) >>> sh;
        lo   = $signed((ACC_W+1)'(INT8_MIN));
        hi   = $signed((ACC_W+1)'(INT8_MAX));
        if (relu_en && t < 0) begin
            t = '0;
        end
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
        q = t[7:0];
    end

endmodule

// File: rtl/fp4_acc_readout.sv
// Readout stage: captures all array accumulators on load and streams them out
// as requantized INT8 bytes or raw 3-byte little-endian values.
module fp4_acc_readout
    import fp4_mm_pkg::*;
#(
    parameter int SLICES = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  load,
    input  logic [num_values(SLICES)*ACC_W-1:0]   acc_flat,
    input  logic [4:0]                            shift,
    input  logic                                  relu_en,
    input  logic                                  raw_mode,
    input  logic                                  out_ready,
    output logic [7:0]                            out_byte,
    output logic                                  out_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic [1:0]                            state_dbg
);

    localparam int N     = num_values(SLICES);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    // Handshake: a byte moves when out_valid & out_ready are both high at a
    // rising clk edge; out_byte is held stable while out_valid & !out_ready,
    // and a same-cycle load wins over the transfer.

    rd_state_e          state_q, state_d;
    logic [ACC_W-1:0]   bank [N];
    logic [4:0]         shift_q;
    logic               relu_q;
    logic               raw_q;
    logic [IDX_W-1:0]   val_idx;
    logic [1:0]         byte_idx;

    logic               xfer;
    logic               last_byte;
    logic               last_val;
    logic [4:0]         shift_clamped;
    logic [7:0]         q_byte;
    logic [7:0]         raw_byte;

    assign xfer          = (state_q == ST_EMIT) && out_ready && !load;
    assign last_byte     = !raw_q || (byte_idx == 2'd2);
    assign last_val      = (val_idx == IDX_W'(N - 1));
    assign shift_clamped = (shift > 5'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : shift;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_EMIT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_EMIT: if (xfer && last_byte && last_val) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            raw_q    <= 1'b0;
            val_idx  <= '0;
            byte_idx <= '0;
            for (int k = 0; k < N; k++) begin
                bank[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (load) begin
                shift_q  <= shift_clamped;
                relu_q   <= relu_en;
                raw_q    <= raw_mode;
                val_idx  <= '0;
                byte_idx <= '0;
                for (int k = 0; k < N; k++) begin
                    bank[k] <= acc_flat[k*ACC_W +: ACC_W];
                end
            end else if (xfer) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    val_idx  <= last_val ? '0 : val_idx + IDX_W'(1);
                    // Advance the bank so the next value sits in entry 0.
                    for (int k = 0; k < N - 1; k++) begin
                        bank[k] <= bank[k+1];
                    end
                    bank[N-1] <= '0;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    fp4_requant u_requant (
        .acc     (bank[0]),
        .shift   (shift_q),
        .relu_en (relu_q),
        .q       (q_byte)
    );

    always_comb begin
        case (byte_idx)
            2'd0:    raw_byte = bank[0][7:0];
            2'd1:    raw_byte = bank[0][15:8];
            default: raw_byte = bank[0][23:16];
        endcase
    end

    assign out_valid = (state_q == ST_EMIT);
    assign busy      = (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE) && !load;
    assign out_byte  = out_valid ? (raw_q ? raw_byte : q_byte) : 8'h00;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fp4_acc_readout.sv
// Self-checking bench for fp4_acc_readout (SLICES=1, two values per readout).
module tb_fp4_acc_readout;

    localparam int W  = 24;
    localparam int NV = 2;
    localparam int FW = NV * W;

    logic          clk;
    logic          reset;
    logic          load;
    logic [FW-1:0] acc_flat;
    logic [4:0]    shift;
    logic          relu_en;
    logic          raw_mode;
    logic          out_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    fp4_acc_readout #(.SLICES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .acc_flat  (acc_flat),
        .shift     (shift),
        .relu_en   (relu_en),
        .raw_mode  (raw_mode),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model: real-valued floor(acc / 2^s + 1/2), then ReLU and clip
    function automatic logic [7:0] model_q(input logic [W-1:0] a, input int sh, input bit relu);
        int     acc_s;
        real    r;
        longint t;
        acc_s = $signed(a);
        if (sh > 23) sh = 23;
        r = $floor($itor(acc_s) / (2.0 ** sh) + 0.5);
        t = longint'(r);
        if (relu && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    task automatic push_model(input logic [FW-1:0] flat, input int sh, input bit relu, input bit raw);
        logic [W-1:0] a;
        for (int k = 0; k < NV; k++) begin
            a = flat[k*W +: W];
            if (raw) begin
                exp_q.push_back(a[7:0]);
                exp_q.push_back(a[15:8]);
                exp_q.push_back(a[23:16]);
            end else begin
                exp_q.push_back(model_q(a, sh, relu));
            end
        end
    endtask

    // drivers
    task automatic do_load(input logic [FW-1:0] flat, input logic [4:0] sh, input bit relu, input bit raw);
        @(negedge clk);
        acc_flat  = flat;
        shift     = sh;
        relu_en   = relu;
        raw_mode  = raw;
        load      = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Consume bytes until the scoreboard empties, then check the done pulse.
    task automatic drain(input int ready_pct);
        int cycles;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 400) begin
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (out_valid && out_ready) begin
                check("out_byte", out_byte, exp_q.pop_front());
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b0);
        @(negedge clk);
        check("done_cleared", done, 1'b0);
        check("state_idle", state_dbg, 2'd0);
    endtask

    typedef struct {
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic [4:0]   sh;
        bit           relu;
        bit           raw;
        int           nb;
        logic [47:0]  e;     // expected byte i at e[8*i +: 8]
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [FW-1:0] flat;
        int sh_r;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        load      = 1'b0;
        acc_flat  = '0;
        shift     = '0;
        relu_en   = 1'b0;
        raw_mode  = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{24'd1152,    -24'd300,   5'd4,  0, 0, 2, 48'h0000_0000_ED48};
        vecs[1] = '{24'd24,      -24'd24,    5'd4,  0, 0, 2, 48'h0000_0000_FF02};
        vecs[2] = '{24'd1000000, 24'd0,      5'd10, 0, 0, 2, 48'h0000_0000_007F};
        vecs[3] = '{-24'd300,    -24'd1,     5'd0,  1, 0, 2, 48'h0000_0000_0000};
        vecs[4] = '{24'd127,     24'd128,    5'd0,  1, 0, 2, 48'h0000_0000_7F7F};
        vecs[5] = '{24'h123456,  24'hFEDCBA, 5'd0,  0, 1, 6, 48'hFEDC_BA12_3456};
        vecs[6] = '{24'h7FFFFF,  24'h800000, 5'd31, 0, 0, 2, 48'h0000_0000_FF01};
        vecs[7] = '{24'hFFFFFF,  24'h800001, 5'd5,  1, 1, 6, 48'h8000_01FF_FFFF};

        repeat (3) @(negedge clk);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_load({vecs[i].a1, vecs[i].a0}, vecs[i].sh, vecs[i].relu, vecs[i].raw);
            check("valid_after_load", out_valid, 1'b1);
            check("busy_after_load", busy, 1'b1);
            for (int b = 0; b < vecs[i].nb; b++) exp_q.push_back(vecs[i].e[8*b +: 8]);
            drain(100);
        end

        // backpressure mid-stream in raw mode: byte held, none skipped
        do_load({24'hFEDCBA, 24'h123456}, 5'd0, 0, 1);
        out_ready = 1'b1;
        #1 check("bp_first", out_byte, 8'h56);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_byte", out_byte, 8'h34);
            check("bp_hold_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        exp_q = '{8'h34, 8'h12, 8'hBA, 8'hDC, 8'hFE};
        drain(100);

        // restart after the first byte: new value 0 next, no done pulse
        do_load({24'd640, 24'd320}, 5'd6, 0, 0);
        out_ready = 1'b1;
        #1 check("rs_first", out_byte, 8'h05);
        @(negedge clk);
        acc_flat  = {-24'd64, 24'd2000};
        shift     = 5'd3;
        relu_en   = 1'b0;
        raw_mode  = 1'b0;
        load      = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        out_ready = 1'b0;
        check("rs_new_first", out_byte, 8'h7F);
        check("rs_no_done", done, 1'b0);
        check("rs_busy", busy, 1'b1);
        exp_q = '{8'h7F, 8'hF8};
        drain(100);

        // reset mid-stream: immediate return to idle, no done pulse
        do_load({24'd5, 24'd6}, 5'd0, 0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_valid", out_valid, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_byte", out_byte, 8'h00);
        for (int c = 0; c < 4; c++) begin
            check("mr_no_done", done, 1'b0);
            @(negedge clk);
        end

        // randomized readouts against the reference model
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < NV; k++) begin
                if ($urandom_range(2) == 0)
                    flat[k*W +: W] = W'($urandom_range(0, 1023)) - W'(512);
                else
                    flat[k*W +: W] = W'($urandom);
            end
            sh_r = $urandom_range(0, 31);
            relu_en  = $urandom_range(1);
            raw_mode = $urandom_range(1);
            push_model(flat, sh_r, relu_en, raw_mode);
            do_load(flat, 5'(sh_r), relu_en, raw_mode);
            drain($urandom_range(30, 100));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
